// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
//
// Purpose: bundles the command handshake, the ALU operand/result bus, the
// architectural flags and the debug read port of alu_sequencer.
//
// Signals:
//   cmd_valid / cmd_ready        command handshake (accept when both high)
//   cmd_op[4:0]                  ALU opcode of the command
//   cmd_dst[1:0]                 register feeding A, also the write-back target
//   cmd_src[1:0]                 register feeding B
//   cmd_imm_sel, cmd_imm[7:0]    immediate B operand (only with ALU_SEQ_IMM_EN)
//   alu_a, alu_b[7:0], alu_op    registered operands/opcode to the ALU
//   alu_result[7:0], alu_cf/zf/sf  registered ALU outputs
//   done                         one-cycle pulse in the write-back cycle
//   cf, zf, sf                   architectural flags
//   rd_sel[1:0] / rd_data[7:0]   combinational debug read of the register file
//
// Modports: slave = the sequencer, master = the surrounding core / ALU side.
// -----------------------------------------------------------------------------
interface alu_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src;
    logic       cmd_imm_sel;
    logic [7:0] cmd_imm;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_cf;
    logic       alu_zf;
    logic       alu_sf;

    logic       done;
    logic       cf;
    logic       zf;
    logic       sf;

    logic [1:0] rd_sel;
    logic [7:0] rd_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm_sel, cmd_imm,
        input  alu_result, alu_cf, alu_zf, alu_sf,
        input  rd_sel,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        output done, cf, zf, sf,
        output rd_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm_sel, cmd_imm,
        output alu_result, alu_cf, alu_zf, alu_sf,
        output rd_sel,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        input  done, cf, zf, sf,
        input  rd_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose: operand-fetch and write-back stage around the 8-bit registered ALU.
// Holds a 4 x 8-bit register file, accepts one register-to-register command
// at a time (IDLE -> EXEC -> WB -> IDLE, one command per 3 cycles), drives the
// ALU operands, waits out the ALU's one-cycle latency, then writes the result
// back and latches the flags.
//
// Parameters:
//   IDLE_OP   opcode driven to the ALU when nothing is in flight; it must hit
//             the ALU's default branch so the ALU keeps its result and CF.
//
// Ports:
//   clk       system clock (shared with the ALU)
//   reset     synchronous, active-high
//   bus       alu_seq_if.slave: command handshake, ALU bus, flags, debug read
//
// Configuration macro:
//   ALU_SEQ_IMM_EN  when defined, cmd_imm_sel=1 selects cmd_imm as operand B;
//                   when undefined, B is always rf[cmd_src] and the immediate
//                   inputs are ignored.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter logic [4:0] IDLE_OP = 5'b01111
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // CMP and TST share op[4:1]; they update flags but never write a register.
    localparam logic [3:0] OP_CMP_TST_HI = 4'b0101;

    state_e     state_q;
    logic [7:0] rf_q [4];
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [4:0] alu_op_q;
    logic [1:0] dst_q;
    logic       wb_en_q;
    logic       done_q;
    logic       cf_q;
    logic       zf_q;
    logic       sf_q;

    logic [7:0] operand_b;

`ifdef ALU_SEQ_IMM_EN
    assign operand_b = bus.cmd_imm_sel ? bus.cmd_imm : rf_q[bus.cmd_src];
`else
    assign operand_b = rf_q[bus.cmd_src];

    // Immediate inputs exist on the interface but have no function here.
    logic unused_imm;
    assign unused_imm = ^{bus.cmd_imm_sel, bus.cmd_imm};
`endif

    // Single FSM process: state, operand registers, register file and flags
    // all advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 5'b00000;      // ADD 0+0: the ALU settles to CF=0 ZF=1 SF=0
            dst_q    <= '0;
            wb_en_q  <= 1'b0;
            done_q   <= 1'b0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            // NOTE: the register file is four plain flops, so it is reset like
            // any other state; a RAM macro could not be cleared this way.
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            // NOTE: every assignment in this clocked process is non-blocking so
            // each right-hand side sees the pre-edge value of every register.
            case (state_q)
                ST_IDLE: begin
                    alu_op_q <= IDLE_OP;
                    if (bus.cmd_valid) begin
                        // dst==src reads the same pre-command value for A and B.
                        alu_a_q  <= rf_q[bus.cmd_dst];
                        alu_b_q  <= operand_b;
                        alu_op_q <= bus.cmd_op;
                        dst_q    <= bus.cmd_dst;
                        wb_en_q  <= (bus.cmd_op[4:1] != OP_CMP_TST_HI);
                        state_q  <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    // The ALU captures the command at the end of this cycle.
                    // Switching to IDLE_OP right away stops it re-executing the
                    // command during WB, which for ADC/SBC/RCL/RCR would advance
                    // its internal carry past the value latched into cf.
                    alu_op_q <= IDLE_OP;
                    done_q   <= 1'b1;
                    state_q  <= ST_WB;
                end

                ST_WB: begin
                    done_q   <= 1'b0;
                    cf_q     <= bus.alu_cf;
                    zf_q     <= bus.alu_zf;
                    sf_q     <= bus.alu_sf;
                    if (wb_en_q) begin
                        rf_q[dst_q] <= bus.alu_result;
                    end
                    alu_op_q <= IDLE_OP;
                    state_q  <= ST_IDLE;
                end

                default: begin
                    done_q   <= 1'b0;
                    alu_op_q <= IDLE_OP;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready only in IDLE and never while reset is asserted.
    assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;

    // A reset that lands in WB aborts the command, so the pulse is suppressed.
    assign bus.done      = done_q && !reset;

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.cf        = cf_q;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
    assign bus.rd_data   = rf_q[bus.rd_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer. Contains a behavioural registered 8-bit ALU that
// the sequencer drives, and a transaction-level reference model (register
// file array + ALU carry) that is updated once per accepted command.
// ALU opcode map used by the bench: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR,
// 6 XOR, 7 INC, 8 DEC, 9 RCL, 10 CMP, 11 TST, 12 RCR; all other opcodes take
// the default branch (result and flags retained).
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam logic [4:0] IDLE_OP = 5'b01111;
    localparam logic [4:0] OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2;
    localparam logic [4:0] OP_SBC = 5'd3,  OP_AND = 5'd4,  OP_OR  = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6,  OP_INC = 5'd7,  OP_DEC = 5'd8;
    localparam logic [4:0] OP_RCL = 5'd9,  OP_CMP = 5'd10, OP_TST = 5'd11;
    localparam logic [4:0] OP_RCR = 5'd12;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       s;
    } alu_out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if bus ();

    alu_sequencer #(.IDLE_OP(IDLE_OP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- ALU behaviour ----------------
    function automatic alu_out_t alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] op, input alu_out_t prev);
        logic [8:0] w;
        alu_out_t   o;
        w = '0;
        case (op)
            OP_ADD:         w = {1'b0, a} + {1'b0, b};
            OP_ADC:         w = {1'b0, a} + {1'b0, b} + {8'd0, prev.c};
            OP_SUB, OP_CMP: w = {1'b0, a} - {1'b0, b};
            OP_SBC:         w = {1'b0, a} - {1'b0, b} - {8'd0, prev.c};
            OP_AND, OP_TST: w = {1'b0, a & b};
            OP_OR:          w = {1'b0, a | b};
            OP_XOR:         w = {1'b0, a ^ b};
            OP_INC:         w = {prev.c, b + 8'd1};
            OP_DEC:         w = {prev.c, b - 8'd1};
            OP_RCL:         w = {a, prev.c};
            OP_RCR:         w = {a[0], prev.c, a[7:1]};
            default:        return prev;
        endcase
        o.r = w[7:0];
        o.c = w[8];
        o.z = (w[7:0] == 8'd0);
        o.s = w[7];
        return o;
    endfunction

    // Registered ALU with no reset of its own.
    alu_out_t alu_q;
    always @(posedge clk) alu_q <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op, alu_q);
    assign bus.alu_result = alu_q.r;
    assign bus.alu_cf     = alu_q.c;
    assign bus.alu_zf     = alu_q.z;
    assign bus.alu_sf     = alu_q.s;

    // ---------------- reference model ----------------
    logic [3:0][7:0] m_rf;
    alu_out_t        m_alu;
    logic [2:0]      m_flags;     // {cf, zf, sf}

    task automatic model_reset();
        m_rf    = '0;
        m_alu   = '{r: 8'd0, c: 1'b0, z: 1'b1, s: 1'b0};
        m_flags = 3'b000;
    endtask

    task automatic model_apply(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] src,
                               input logic isel, input logic [7:0] imm);
        logic [7:0] b;
`ifdef ALU_SEQ_IMM_EN
        b = isel ? imm : m_rf[src];
`else
        b = m_rf[src];
`endif
        m_alu = alu_fn(m_rf[dst], b, op, m_alu);
        if (!(op == OP_CMP || op == OP_TST)) m_rf[dst] = m_alu.r;
        m_flags = {m_alu.c, m_alu.z, m_alu.s};
    endtask

    // ---------------- stimulus helpers ----------------
    // Issues one command; lat = cycles from accept edge to done (-1 on timeout).
    // Returns at +1ns of the first cycle after write-back.
    task automatic exec_cmd(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] src,
                            input logic isel, input logic [7:0] imm, output int lat);
        int waited;
        lat = -1;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_dst     = dst;
        bus.cmd_src     = src;
        bus.cmd_imm_sel = isel;
        bus.cmd_imm     = imm;
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b0;
        model_apply(op, dst, src, isel, imm);
        for (int c = 1; c <= 8; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_rf(output logic [3:0][7:0] r);
        for (int i = 0; i < 4; i++) begin
            bus.rd_sel = 2'(i);
            #1;
            r[i] = bus.rd_data;
        end
    endtask

    // Loads an arbitrary value using only XOR/ADD/INC on the register itself.
    task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
        int lat;
        exec_cmd(OP_XOR, idx, idx, 1'b0, 8'h00, lat);
        for (int b = 7; b >= 0; b--) begin
            exec_cmd(OP_ADD, idx, idx, 1'b0, 8'h00, lat);
            if (val[b]) exec_cmd(OP_INC, idx, idx, 1'b0, 8'h00, lat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0][7:0] r;
        reset = 1'b1;
        bus.cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: observed %b expected 0", bus.cmd_ready);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: observed %b expected 0", bus.done);
        end
        vectors++;
        if ({bus.cf, bus.zf, bus.sf} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: observed %b expected 000", {bus.cf, bus.zf, bus.sf});
        end
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_alu_bus: observed %h/%h/%h expected 00/00/00", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        read_rf(r);
        vectors++;
        if (r !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rf: observed %h expected 00000000", r);
        end
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_ready: observed %b expected 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.alu_op !== IDLE_OP) begin
            miscompares++;
            $display("FAIL idle_op: observed %b expected %b", bus.alu_op, IDLE_OP);
        end
        model_reset();
    endtask

    task automatic test_add_zero();
        int lat;
        logic [3:0][7:0] r;
        exec_cmd(OP_ADD, 2'd0, 2'd0, 1'b0, 8'h00, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL add0_latency: observed %0d expected 2", lat);
        end
        read_rf(r);
        vectors++;
        if (r[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL add0_r0: observed %h expected 00", r[0]);
        end
        vectors++;
        if ({bus.cf, bus.zf, bus.sf} !== 3'b010) begin
            miscompares++;
            $display("FAIL add0_flags: observed %b expected 010", {bus.cf, bus.zf, bus.sf});
        end
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL add0_after_wb: observed ready=%b done=%b expected ready=1 done=0", bus.cmd_ready, bus.done);
        end
    endtask

    task automatic test_cmp();
        int lat;
        logic [3:0][7:0] r;
        load_reg(2'd0, 8'h05);
        load_reg(2'd1, 8'h07);
        exec_cmd(OP_CMP, 2'd0, 2'd1, 1'b0, 8'h00, lat);
        read_rf(r);
        vectors++;
        if (r[0] !== 8'h05 || r[1] !== 8'h07) begin
            miscompares++;
            $display("FAIL cmp_regs: observed r0=%h r1=%h expected r0=05 r1=07", r[0], r[1]);
        end
        vectors++;
        if ({bus.cf, bus.zf, bus.sf} !== 3'b101) begin
            miscompares++;
            $display("FAIL cmp_flags: observed %b expected 101", {bus.cf, bus.zf, bus.sf});
        end
    endtask

`ifdef ALU_SEQ_IMM_EN
    task automatic test_imm();
        int lat;
        logic [3:0][7:0] r;
        exec_cmd(OP_XOR, 2'd1, 2'd1, 1'b0, 8'h00, lat);
        exec_cmd(OP_XOR, 2'd2, 2'd2, 1'b0, 8'h00, lat);
        exec_cmd(OP_ADD, 2'd1, 2'd3, 1'b1, 8'hFF, lat);
        exec_cmd(OP_ADD, 2'd1, 2'd3, 1'b1, 8'h01, lat);
        read_rf(r);
        vectors++;
        if (r[1] !== 8'h00 || {bus.cf, bus.zf} !== 2'b11) begin
            miscompares++;
            $display("FAIL imm_add: observed r1=%h cf/zf=%b expected r1=00 cf/zf=11", r[1], {bus.cf, bus.zf});
        end
        exec_cmd(OP_ADC, 2'd2, 2'd3, 1'b1, 8'h00, lat);
        read_rf(r);
        vectors++;
        if (r[2] !== 8'h01 || bus.cf !== 1'b0) begin
            miscompares++;
            $display("FAIL imm_adc: observed r2=%h cf=%b expected r2=01 cf=0", r[2], bus.cf);
        end
    endtask
`else
    task automatic test_no_imm();
        int lat;
        logic [3:0][7:0] r;
        load_reg(2'd0, 8'h0F);
        load_reg(2'd1, 8'hF0);
        exec_cmd(OP_XOR, 2'd0, 2'd1, 1'b1, 8'hAA, lat);
        read_rf(r);
        vectors++;
        if (r[0] !== 8'hFF || bus.sf !== 1'b1) begin
            miscompares++;
            $display("FAIL no_imm_xor: observed r0=%h sf=%b expected r0=ff sf=1", r[0], bus.sf);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [4:0] ops  [3] = '{OP_ADD, OP_SUB, OP_XOR};
        logic [1:0] dsts [3] = '{2'd0, 2'd2, 2'd3};
        logic [1:0] srcs [3] = '{2'd1, 2'd0, 2'd2};
        logic [8:0] rdy;
        logic [8:0] dn;
        logic [3:0][7:0] r;
        int k;
        load_reg(2'd0, 8'h33);
        load_reg(2'd1, 8'h44);
        load_reg(2'd2, 8'h99);
        k = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_imm_sel = 1'b0;
        bus.cmd_op      = ops[0];
        bus.cmd_dst     = dsts[0];
        bus.cmd_src     = srcs[0];
        for (int cyc = 0; cyc < 9; cyc++) begin
            rdy[cyc] = bus.cmd_ready;
            dn[cyc]  = bus.done;
            @(posedge clk); #1;
            if (rdy[cyc] && k < 3) begin
                model_apply(ops[k], dsts[k], srcs[k], 1'b0, 8'h00);
                k++;
                if (k < 3) begin
                    bus.cmd_op  = ops[k];
                    bus.cmd_dst = dsts[k];
                    bus.cmd_src = srcs[k];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (rdy !== 9'b001001001) begin
            miscompares++;
            $display("FAIL b2b_ready_pattern: observed %b expected 001001001", rdy);
        end
        vectors++;
        if (dn !== 9'b100100100) begin
            miscompares++;
            $display("FAIL b2b_done_pattern: observed %b expected 100100100", dn);
        end
        read_rf(r);
        vectors++;
        if (r !== m_rf) begin
            miscompares++;
            $display("FAIL b2b_rf: observed %h expected %h", r, m_rf);
        end
        vectors++;
        if ({bus.cf, bus.zf, bus.sf} !== m_flags) begin
            miscompares++;
            $display("FAIL b2b_flags: observed %b expected %b", {bus.cf, bus.zf, bus.sf}, m_flags);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [3:0][7:0] r;
        logic [1:0] dn;
        load_reg(2'd3, 8'h10);
        load_reg(2'd2, 8'h80);
        exec_cmd(OP_ADD, 2'd2, 2'd2, 1'b0, 8'h00, lat);   // leaves ALU carry = 1
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_INC;
        bus.cmd_dst   = 2'd3;
        bus.cmd_src   = 2'd3;
        bus.cmd_imm_sel = 1'b0;
        @(posedge clk); #1;                                // now in EXEC
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        dn[0] = bus.done;
        @(posedge clk); #1;
        dn[1] = bus.done;
        reset = 1'b0;
        model_reset();
        vectors++;
        if (dn !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_done: observed %b expected 00", dn);
        end
        read_rf(r);
        vectors++;
        if (r !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_rf: observed %h expected 00000000", r);
        end
        exec_cmd(OP_ADC, 2'd0, 2'd1, 1'b0, 8'h00, lat);
        read_rf(r);
        vectors++;
        if (lat !== 2 || r[0] !== 8'h00 || {bus.cf, bus.zf, bus.sf} !== 3'b010) begin
            miscompares++;
            $display("FAIL abort_adc: observed lat=%0d r0=%h flags=%b expected lat=2 r0=00 flags=010",
                     lat, r[0], {bus.cf, bus.zf, bus.sf});
        end
    endtask

    task automatic test_random();
        int lat;
        logic [3:0][7:0] r;
        logic [4:0] op;
        logic [1:0] dst, src;
        logic       isel;
        logic [7:0] imm;
        for (int n = 0; n < 60; n++) begin
            op   = 5'($urandom_range(0, 12));
            dst  = 2'($urandom_range(0, 3));
            src  = 2'($urandom_range(0, 3));
            isel = 1'($urandom_range(0, 1));
            imm  = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            exec_cmd(op, dst, src, isel, imm, lat);
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: observed %0d expected 2", n, lat);
            end
            read_rf(r);
            vectors++;
            if (r !== m_rf) begin
                miscompares++;
                $display("FAIL rand_rf[%0d] op=%0d: observed %h expected %h", n, op, r, m_rf);
            end
            vectors++;
            if ({bus.cf, bus.zf, bus.sf} !== m_flags) begin
                miscompares++;
                $display("FAIL rand_flags[%0d] op=%0d: observed %b expected %b", n, op, {bus.cf, bus.zf, bus.sf}, m_flags);
            end
        end
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 5'd0;
        bus.cmd_dst     = 2'd0;
        bus.cmd_src     = 2'd0;
        bus.cmd_imm_sel = 1'b0;
        bus.cmd_imm     = 8'h00;
        bus.rd_sel      = 2'd0;
        model_reset();
        test_reset();
        test_add_zero();
        test_cmp();
`ifdef ALU_SEQ_IMM_EN
        test_imm();
`else
        test_no_imm();
`endif
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within 400000 ns");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operand-fetch and write-back stage wrapped around the 8-bit `alu`. It accepts one register-to-register command at a time and holds a 4 x 8-bit register file. It drives `A`/`B`/`operation` into the ALU and waits out the ALU's one-cycle registered latency. It then writes the result back and latches the flags for the rest of the core.

## Interface
Parameters:
- `IDLE_OP`, 5'b01111: opcode driven to the ALU when no command is in flight. Must hit the ALU's default branch so its CF is retained.

Ports:
- `clk`  in  1  system clock; the ALU shares it.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_op`  in  5  ALU opcode.
- `cmd_dst`  in  2  register index; feeds A and is the write-back target.
- `cmd_src`  in  2  register index; feeds B.
- `cmd_imm_sel`  in  1  use `cmd_imm` as B (only with `ALU_SEQ_IMM_EN`).
- `cmd_imm`  in  8  immediate operand (only with `ALU_SEQ_IMM_EN`).
- `alu_a`, `alu_b`  out  8 each  registered operands to the ALU.
- `alu_op`  out  5  registered opcode to the ALU.
- `alu_result`  in  8  ALU `result`.
- `alu_cf`, `alu_zf`, `alu_sf`  in  1 each  ALU flags.
- `done`  out  1  one-cycle pulse in the write-back cycle.
- `cf`, `zf`, `sf`  out  1 each  architectural flags.
- `rd_sel`  in  2  debug read index.
- `rd_data`  out  8  combinational read of `rf[rd_sel]`.

## Operation
- States: IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - `cmd_ready`=1 and `alu_op`<=`IDLE_OP`.
  - On `cmd_valid`: latch `alu_a`<=`rf[cmd_dst]`, `alu_b`<=`rf[cmd_src]` (or `cmd_imm`), `alu_op`<=`cmd_op`, and the destination index.
  - Go to EXEC.
- EXEC: operands are held stable while the ALU samples them at the end of the cycle. Go to WB.
- WB:
  - `done`=1.
  - At the end of the cycle, `cf`/`zf`/`sf` <= `alu_cf`/`alu_zf`/`alu_sf`.
  - `rf[dst]` <= `alu_result`, unless `op[4:1]`==4'b0101 (CMP/TST). Those update flags only.
  - `alu_op`<=`IDLE_OP`. Go to IDLE.
- INC/DEC ignore A in the ALU; the sequencer still drives `rf[dst]` on A and writes back to `dst`.
- ADC/SBC/RCL/RCR consume the ALU's internal CF. `IDLE_OP` preserves it between commands, so `cf` and the ALU carry always agree.
- Register file writes come only from WB; there is no external write port.
- `cmd_*` is ignored when `cmd_ready`=0 (no queuing).

## Timing
- Reset values:
  - state IDLE; `rf[0..3]`=0.
  - `alu_a`=`alu_b`=0, `alu_op`=5'b00000 (ADD).
  - `cf`=0, `zf`=0, `sf`=0, `done`=0.
  - `cmd_ready`=0 while `reset` is high.
- The ALU sees ADD 0+0 during reset. Its CF/ZF/SF therefore settle to 0/1/0 before the first command, so an ADC after reset uses carry 0.
- Command accepted at edge N (end of IDLE cycle):
  - EXEC is cycle N+1.
  - ALU registers its result at the end of N+1.
  - WB is cycle N+2 with `done`=1; rf/flags update at the end of N+2.
  - `cmd_ready` is high again in cycle N+3.
- Throughput is one command per 3 cycles.
- A command in cycle N+3 reading `dst` from the prior command sees the written value; no bypass is needed.
- `reset` asserted in EXEC or WB aborts the command: no rf write, no flag update, no `done`.
- `dst`==`src`: both operands are that register's pre-command value.

## Configuration
- `ALU_SEQ_IMM_EN` defined: `cmd_imm_sel`=1 selects `cmd_imm` as B at accept; `cmd_src` is ignored.
- `ALU_SEQ_IMM_EN` undefined:
  - `cmd_imm_sel` and `cmd_imm` are present but unused.
  - B is always `rf[cmd_src]` and no immediate mux is synthesised.

## Test plan
- Reset, then ADD r0,r0 -> `done` two cycles after accept, `rf[0]`=0x00, `zf`=1, `cf`=0, `sf`=0.
- With IMM: ADD r1,#0xFF; ADD r1,#0x01 -> `rf[1]`=0x00, `cf`=1, `zf`=1. Then ADC r2,#0x00 -> `rf[2]`=0x01, `cf`=0.
- r0=0x05, r1=0x07: CMP r0,r1 -> `rf[0]` stays 0x05, `cf`=1, `sf`=1, `zf`=0.
- `cmd_valid` held high continuously with three commands -> accepts exactly every 3rd cycle, `cmd_ready` low in EXEC/WB, results in order.
- `reset` pulsed in EXEC of INC r3 (r3=0x10) -> r3=0x00 after reset, no `done`. The next ADC carries in 0.
- Without IMM: `cmd_imm_sel`=1, `cmd_imm`=0xAA, XOR r0,r1 (r0=0x0F, r1=0xF0) -> `rf[0]`=0xFF, `sf`=1.
